// File: rtl/game_sequencer.sv
// Frame-rate game sequencer: start key handling, scoring, scroll episodes and
// platform placement for a single-ball bounce game.
module game_sequencer #(
  parameter int unsigned SCROLL_LINE   = 240,
  parameter int unsigned SCROLL_FRAMES = 30,
  parameter int unsigned SCROLL_STEP   = 2,
  parameter logic [7:0]  START_KEY     = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] ball_y,
  input  logic       bounce,
  output logic [1:0] game_state,
  output logic       ball_reset,
  output logic [1:0] scroll_dy,
  output logic [6:0] score,
  output logic [6:0] hi_score,
  output logic [9:0] plat_x0,
  output logic [9:0] plat_x1,
  output logic [9:0] plat_x2,
  output logic [9:0] plat_y0,
  output logic [9:0] plat_y1,
  output logic [9:0] plat_y2
);

  typedef enum logic [1:0] {
    ATTRACT = 2'b00,
    PLAY    = 2'b01,
    SCROLL  = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int unsigned  CNT_W    = $clog2(SCROLL_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCROLL_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [9:0]   LINE     = 10'(SCROLL_LINE);
  localparam logic [10:0]  STEP11   = 11'(SCROLL_STEP);
  localparam logic [1:0]   STEP2    = 2'(SCROLL_STEP);
  localparam logic [6:0]   SCORE_MAX = 7'd99;
  localparam logic [9:0]   DEF_X [3] = '{10'd240, 10'd165, 10'd317};
  localparam logic [9:0]   DEF_Y [3] = '{10'd470, 10'd455, 10'd450};

  state_t           state;
  logic [CNT_W-1:0] scroll_cnt;
  logic [9:0]       lfsr;
  logic             key_prev;
  logic [9:0]       px [3];
  logic [9:0]       py [3];

  logic             key_now;
  logic             key_press;
  logic [10:0]      ball_bottom;
  logic             bottom;
  logic [6:0]       score_inc;
  logic [8:0]       slice [3];
  logic [10:0]      y_sum [3];
  logic [9:0]       x_scrolled [3];
  logic [9:0]       y_scrolled [3];

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    key_now     = (keycode == START_KEY);
    key_press   = key_now && !key_prev;
    ball_bottom = {1'b0, ball_y} + 11'd10;
    bottom      = (ball_bottom >= 11'd479);
    score_inc   = (score >= SCORE_MAX) ? SCORE_MAX : score + 7'd1;
    slice[0]    = lfsr[8:0];
    slice[1]    = lfsr[9:1];
    slice[2]    = {lfsr[0], lfsr[9:2]};
    for (int i = 0; i < 3; i++) begin
      y_sum[i] = {1'b0, py[i]} + STEP11;
      if (y_sum[i] >= 11'd480) begin
        y_scrolled[i] = 10'd40;
        x_scrolled[i] = 10'd40 + {1'b0, slice[i]};
      end else begin
        y_scrolled[i] = y_sum[i][9:0];
        x_scrolled[i] = px[i];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= ATTRACT;
      ball_reset <= 1'b0;
      scroll_dy  <= 2'd0;
      score      <= 7'd0;
      hi_score   <= 7'd0;
      scroll_cnt <= '0;
      lfsr       <= 10'h3FF;
      key_prev   <= 1'b0;
      px         <= DEF_X;
      py         <= DEF_Y;
    end else begin
      key_prev   <= key_now;
      lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      ball_reset <= 1'b0;
      unique case (state)
        ATTRACT: begin
          if (key_press) begin
            state      <= PLAY;
            score      <= 7'd0;
            px         <= DEF_X;
            py         <= DEF_Y;
            ball_reset <= 1'b1;
          end
        end
        PLAY: begin
          if (bottom) begin
            state <= OVER;
            if (score > hi_score) hi_score <= score;
          end else if (bounce) begin
            score <= score_inc;
            if (ball_y < LINE) begin
              state      <= SCROLL;
              scroll_cnt <= CNT_LOAD;
              scroll_dy  <= STEP2;
            end
          end
        end
        SCROLL: begin
          // A floor hit abandons the scroll on the spot; platforms stay put.
          if (bottom) begin
            state      <= OVER;
            scroll_dy  <= 2'd0;
            scroll_cnt <= '0;
            if (score > hi_score) hi_score <= score;
          end else begin
            if (bounce) score <= score_inc;
            px         <= x_scrolled;
            py         <= y_scrolled;
            scroll_cnt <= scroll_cnt - CNT_ONE;
            if (scroll_cnt == CNT_ONE) begin
              state     <= PLAY;
              scroll_dy <= 2'd0;
            end
          end
        end
        OVER: begin
          if (key_press) state <= ATTRACT;
        end
        default: state <= ATTRACT;
      endcase
    end
  end

  assign game_state = state;
  assign plat_x0    = px[0];
  assign plat_x1    = px[1];
  assign plat_x2    = px[2];
  assign plat_y0    = py[0];
  assign plat_y1    = py[1];
  assign plat_y2    = py[2];

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario tests plus a randomized run against a frame-level behavioural model.
module tb_game_sequencer;

  localparam logic [7:0] KEY = 8'h2C;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] ball_y;
  logic       bounce;
  logic [1:0] game_state;
  logic       ball_reset;
  logic [1:0] scroll_dy;
  logic [6:0] score;
  logic [6:0] hi_score;
  logic [9:0] plat_x0, plat_x1, plat_x2;
  logic [9:0] plat_y0, plat_y1, plat_y2;

  int checks = 0;
  int errors = 0;

  game_sequencer dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .ball_y    (ball_y),
    .bounce    (bounce),
    .game_state(game_state),
    .ball_reset(ball_reset),
    .scroll_dy (scroll_dy),
    .score     (score),
    .hi_score  (hi_score),
    .plat_x0   (plat_x0),
    .plat_x1   (plat_x1),
    .plat_x2   (plat_x2),
    .plat_y0   (plat_y0),
    .plat_y1   (plat_y1),
    .plat_y2   (plat_y2)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: game modes 0 attract, 1 play, 2 scroll, 3 over.
  int m_state, m_score, m_hi, m_remain, m_lfsr, m_dy;
  bit m_prev, m_br;
  int m_px [3];
  int m_py [3];

  function automatic int bump(int s);
    return (s < 99) ? s + 1 : 99;
  endfunction

  function automatic int lfsr_slice(int l, int p);
    case (p)
      0:       return l % 512;
      1:       return l / 2;
      default: return (l % 2) * 256 + l / 4;
    endcase
  endfunction

  task automatic model_defaults();
    m_px = '{240, 165, 317};
    m_py = '{470, 455, 450};
  endtask

  task automatic model_step(input bit rst, input logic [7:0] kc, input int by, input bit bnc);
    bit kp, bot;
    int l;
    if (rst) begin
      m_state = 0; m_score = 0; m_hi = 0; m_remain = 0; m_lfsr = 'h3FF;
      m_prev = 0; m_br = 0; m_dy = 0;
      model_defaults();
      return;
    end
    kp     = (kc == KEY) && !m_prev;
    m_prev = (kc == KEY);
    bot    = (by + 10 >= 479);
    l      = m_lfsr;
    m_lfsr = ((l * 2) % 1024) + (((l / 512) + (l / 64)) % 2);
    m_br   = 0;
    case (m_state)
      0: if (kp) begin
        m_state = 1; m_score = 0; m_br = 1;
        model_defaults();
      end
      1: if (bot) begin
        m_state = 3; if (m_score > m_hi) m_hi = m_score;
      end else if (bnc) begin
        m_score = bump(m_score);
        if (by < 240) begin m_state = 2; m_remain = 30; end
      end
      2: if (bot) begin
        m_state = 3; m_remain = 0; if (m_score > m_hi) m_hi = m_score;
      end else begin
        if (bnc) m_score = bump(m_score);
        for (int p = 0; p < 3; p++) begin
          if (m_py[p] + 2 >= 480) begin
            m_py[p] = 40;
            m_px[p] = 40 + lfsr_slice(l, p);
          end else begin
            m_py[p] = m_py[p] + 2;
          end
        end
        m_remain = m_remain - 1;
        if (m_remain == 0) m_state = 1;
      end
      default: if (kp) m_state = 0;
    endcase
    m_dy = (m_state == 2) ? 2 : 0;
  endtask

  task automatic tick(input bit rst, input logic [7:0] kc, input logic [9:0] by, input bit bnc);
    Reset = rst; keycode = kc; ball_y = by; bounce = bnc;
    @(posedge frame_clk);
    model_step(rst, kc, int'(by), bnc);
    #1;
  endtask

  string names [11] = '{"game_state", "ball_reset", "scroll_dy", "score", "hi_score",
                        "plat_x0", "plat_x1", "plat_x2", "plat_y0", "plat_y1", "plat_y2"};

  function automatic logic [31:0] dut_val(int k);
    case (k)
      0:  return 32'(game_state);
      1:  return 32'(ball_reset);
      2:  return 32'(scroll_dy);
      3:  return 32'(score);
      4:  return 32'(hi_score);
      5:  return 32'(plat_x0);
      6:  return 32'(plat_x1);
      7:  return 32'(plat_x2);
      8:  return 32'(plat_y0);
      9:  return 32'(plat_y1);
      default: return 32'(plat_y2);
    endcase
  endfunction

  function automatic logic [31:0] model_val(int k);
    case (k)
      0:  return 32'(m_state);
      1:  return 32'(m_br);
      2:  return 32'(m_dy);
      3:  return 32'(m_score);
      4:  return 32'(m_hi);
      5:  return 32'(m_px[0]);
      6:  return 32'(m_px[1]);
      7:  return 32'(m_px[2]);
      8:  return 32'(m_py[0]);
      9:  return 32'(m_py[1]);
      default: return 32'(m_py[2]);
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] exp_vals [11];
    exp_vals = '{0, 0, 0, 0, 0, 240, 165, 317, 470, 455, 450};
    tick(1, 8'h00, 10'd300, 0);
    tick(1, 8'h00, 10'd300, 0);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (dut_val(k) !== exp_vals[k]) begin
        errors++;
        $display("FAIL reset_%s: got %0d expected %0d", names[k], dut_val(k), exp_vals[k]);
      end
    end
  endtask

  task automatic test_start_key();
    int pulses = 0;
    tick(0, 8'h00, 10'd300, 0);
    for (int f = 0; f < 5; f++) begin
      tick(0, KEY, 10'd300, 0);
      if (ball_reset === 1'b1) pulses++;
      if (f == 0) begin
        checks++;
        if (game_state !== 2'b01 || ball_reset !== 1'b1) begin
          errors++;
          $display("FAIL start_entry: got state %0d ball_reset %0d expected state 1 ball_reset 1",
                   game_state, ball_reset);
        end
      end
    end
    checks++;
    if (pulses !== 1 || game_state !== 2'b01 || score !== 7'd0) begin
      errors++;
      $display("FAIL start_held: got pulses %0d state %0d score %0d expected 1 1 0",
               pulses, game_state, score);
    end
    tick(0, 8'h00, 10'd300, 0);
  endtask

  task automatic test_play_bounce();
    for (int b = 0; b < 3; b++) tick(0, 8'h00, 10'd300, 1);
    checks++;
    if (score !== 7'd3 || game_state !== 2'b01) begin
      errors++;
      $display("FAIL play_bounce: got score %0d state %0d expected 3 1", score, game_state);
    end
    checks++;
    if (plat_y0 !== 10'd470 || plat_y1 !== 10'd455 || plat_y2 !== 10'd450) begin
      errors++;
      $display("FAIL play_plat_y: got %0d %0d %0d expected 470 455 450", plat_y0, plat_y1, plat_y2);
    end
  endtask

  task automatic test_scroll();
    tick(0, 8'h00, 10'd200, 1);
    checks++;
    if (game_state !== 2'b10 || scroll_dy !== 2'd2 || score !== 7'd4) begin
      errors++;
      $display("FAIL scroll_entry: got state %0d dy %0d score %0d expected 2 2 4",
               game_state, scroll_dy, score);
    end
    for (int f = 1; f <= 30; f++) begin
      tick(0, 8'h00, 10'd300, 0);
      if (f == 4) begin
        checks++;
        if (plat_y0 !== 10'd478) begin
          errors++;
          $display("FAIL scroll_y0_f4: got %0d expected 478", plat_y0);
        end
      end
      if (f == 5) begin
        checks++;
        if (plat_y0 !== 10'd40 || plat_x0 < 10'd40 || plat_x0 > 10'd551 || 32'(plat_x0) !== 32'(m_px[0])) begin
          errors++;
          $display("FAIL scroll_wrap: got x0 %0d y0 %0d expected x0 %0d y0 40", plat_x0, plat_y0, m_px[0]);
        end
      end
      if (f == 29) begin
        checks++;
        if (game_state !== 2'b10 || scroll_dy !== 2'd2) begin
          errors++;
          $display("FAIL scroll_f29: got state %0d dy %0d expected 2 2", game_state, scroll_dy);
        end
      end
      for (int k = 5; k < 11; k++) begin
        checks++;
        if (dut_val(k) !== model_val(k)) begin
          errors++;
          $display("FAIL scroll_%s: got %0d expected %0d", names[k], dut_val(k), model_val(k));
        end
      end
    end
    checks++;
    if (game_state !== 2'b01 || scroll_dy !== 2'd0 || plat_y0 !== 10'd90) begin
      errors++;
      $display("FAIL scroll_exit: got state %0d dy %0d y0 %0d expected 1 0 90", game_state, scroll_dy, plat_y0);
    end
  endtask

  task automatic test_saturate_over();
    for (int b = 0; b < 100; b++) tick(0, 8'h00, 10'd300, 1);
    checks++;
    if (score !== 7'd99 || game_state !== 2'b01) begin
      errors++;
      $display("FAIL saturate: got score %0d state %0d expected 99 1", score, game_state);
    end
    tick(0, 8'h00, 10'd470, 1);
    checks++;
    if (game_state !== 2'b11 || score !== 7'd99 || hi_score !== 7'd99) begin
      errors++;
      $display("FAIL over_entry: got state %0d score %0d hi %0d expected 3 99 99", game_state, score, hi_score);
    end
    for (int f = 0; f < 3; f++) tick(0, 8'h00, 10'd100, 1);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (dut_val(k) !== model_val(k)) begin
        errors++;
        $display("FAIL over_frozen_%s: got %0d expected %0d", names[k], dut_val(k), model_val(k));
      end
    end
  endtask

  task automatic test_second_game();
    tick(0, KEY, 10'd300, 0);
    checks++;
    if (game_state !== 2'b00) begin
      errors++;
      $display("FAIL over_to_attract: got %0d expected 0", game_state);
    end
    tick(0, 8'h00, 10'd300, 0);
    tick(0, KEY, 10'd300, 0);
    checks++;
    if (game_state !== 2'b01 || score !== 7'd0 || plat_y0 !== 10'd470 || plat_x0 !== 10'd240) begin
      errors++;
      $display("FAIL game2_start: got state %0d score %0d x0 %0d y0 %0d expected 1 0 240 470",
               game_state, score, plat_x0, plat_y0);
    end
    tick(0, 8'h00, 10'd300, 0);
    for (int b = 0; b < 5; b++) tick(0, 8'h00, 10'd300, 1);
    tick(0, 8'h00, 10'd475, 0);
    checks++;
    if (game_state !== 2'b11 || score !== 7'd5 || hi_score !== 7'd99) begin
      errors++;
      $display("FAIL game2_over: got state %0d score %0d hi %0d expected 3 5 99", game_state, score, hi_score);
    end
  endtask

  task automatic test_reset_mid_scroll();
    tick(0, KEY, 10'd300, 0);
    tick(0, 8'h00, 10'd300, 0);
    tick(0, KEY, 10'd300, 0);
    tick(0, 8'h00, 10'd300, 0);
    tick(0, 8'h00, 10'd239, 1);
    for (int f = 1; f < 10; f++) tick(0, 8'h00, 10'd300, 0);
    checks++;
    if (game_state !== 2'b10 || plat_y0 === 10'd470) begin
      errors++;
      $display("FAIL midscroll_pre: got state %0d y0 %0d expected state 2 and y0 moved", game_state, plat_y0);
    end
    tick(1, 8'h00, 10'd300, 0);
    checks++;
    if (game_state !== 2'b00 || scroll_dy !== 2'd0 || hi_score !== 7'd0 || score !== 7'd0) begin
      errors++;
      $display("FAIL midscroll_reset: got state %0d dy %0d hi %0d score %0d expected 0 0 0 0",
               game_state, scroll_dy, hi_score, score);
    end
    checks++;
    if (plat_x0 !== 10'd240 || plat_y0 !== 10'd470 || plat_x1 !== 10'd165 ||
        plat_y1 !== 10'd455 || plat_x2 !== 10'd317 || plat_y2 !== 10'd450) begin
      errors++;
      $display("FAIL midscroll_plats: got (%0d,%0d) (%0d,%0d) (%0d,%0d) expected (240,470) (165,455) (317,450)",
               plat_x0, plat_y0, plat_x1, plat_y1, plat_x2, plat_y2);
    end
  endtask

  task automatic test_random();
    logic [7:0] kc = 8'h00;
    logic [9:0] by;
    bit rst, bnc;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    kc = KEY;
          2:       kc = 8'h04;
          default: kc = 8'h00;
        endcase
      end
      if ($urandom_range(0, 59) == 0) by = 10'(469 + $urandom_range(0, 10));
      else                            by = 10'($urandom_range(0, 468));
      bnc = ($urandom_range(0, 2) == 0);
      tick(rst, kc, by, bnc);
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (dut_val(k) !== model_val(k)) begin
          errors++;
          $display("FAIL random_%s cycle %0d: got %0d expected %0d", names[k], c, dut_val(k), model_val(k));
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; ball_y = 10'd300; bounce = 1'b0;
    test_reset();
    test_start_key();
    test_play_bounce();
    test_scroll();
    test_saturate_over();
    test_second_game();
    test_reset_mid_scroll();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
